// File: rtl/tiny_cpu_sequencer.sv
// Program sequencer feeding the TinyCPU In bus from a small internal program memory.
// Optional macro TINYSEQ_LOOP_EN adds loop_cnt and repeats the program without bubble cycles.
module tiny_cpu_sequencer #(
  parameter int          DEPTH        = 16,
  parameter int          AW           = 4,
  parameter logic [11:0] IDLE_WORD    = 12'h000,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic          Clk,
  input  logic          CLR,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [12:0]   prog_data,
  input  logic          start,
`ifdef TINYSEQ_LOOP_EN
  input  logic [7:0]    loop_cnt,
`endif
  input  logic [AW-1:0] start_addr,
  output logic [11:0]   cpu_in,
  input  logic [7:0]    cpu_result,
  output logic          busy,
  output logic          done,
  output logic [7:0]    result,
  output logic [AW-1:0] pc,
  output logic          err
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        state_reg;
  logic [CW-1:0] drain_cnt_reg;
  logic [12:0]   mem [DEPTH];
  logic [12:0]   fetch_word;
  logic          last_flag;

`ifdef TINYSEQ_LOOP_EN
  logic [AW-1:0] loop_addr_reg;
  logic [7:0]    loops_left_reg;
`endif

  assign fetch_word = mem[pc];
  assign last_flag  = fetch_word[12];

  // Program memory only accepts writes while idle; contents survive CLR.
  always_ff @(posedge Clk) begin
    if (prog_we && state_reg == S_IDLE) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (CLR) begin
      state_reg      <= S_IDLE;
      cpu_in         <= IDLE_WORD;
      busy           <= 1'b0;
      done           <= 1'b0;
      result         <= 8'h00;
      pc             <= '0;
      err            <= 1'b0;
      drain_cnt_reg  <= '0;
`ifdef TINYSEQ_LOOP_EN
      loop_addr_reg  <= '0;
      loops_left_reg <= 8'h00;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          cpu_in <= IDLE_WORD;
          if (start) begin
            pc        <= start_addr;
            err       <= 1'b0;
            busy      <= 1'b1;
            state_reg <= S_RUN;
`ifdef TINYSEQ_LOOP_EN
            loop_addr_reg  <= start_addr;
            loops_left_reg <= loop_cnt;
`endif
          end
        end

        S_RUN: begin
          cpu_in <= fetch_word[11:0];
`ifdef TINYSEQ_LOOP_EN
          if (last_flag && loops_left_reg != 8'h00) begin
            pc             <= loop_addr_reg;
            loops_left_reg <= loops_left_reg - 8'd1;
          end else
`endif
          if (last_flag) begin
            drain_cnt_reg <= CW'(DRAIN_CYCLES);
            state_reg     <= S_DRAIN;
          end else if (pc == AW'(DEPTH - 1)) begin
            // Ran off the end of memory: stop here instead of wrapping.
            err           <= 1'b1;
            drain_cnt_reg <= CW'(DRAIN_CYCLES);
            state_reg     <= S_DRAIN;
          end else begin
            pc <= pc + AW'(1);
          end
        end

        S_DRAIN: begin
          cpu_in <= IDLE_WORD;
          // Counter reaches zero after DRAIN_CYCLES idle words; capture one edge later.
          if (drain_cnt_reg == '0) begin
            result    <= cpu_result;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - CW'(1);
          end
        end

        default: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
          cpu_in    <= IDLE_WORD;
        end
      endcase
    end
  end

endmodule
